// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate generator with a valid/ready
// handshake and a one-entry skid buffer behind the main output register.
module imm_extend_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err
);

    localparam int unsigned EXT_W = XLEN - IMM_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e            state_q, state_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic            main_err_q, main_err_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_err_q, skid_err_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] sext_c;
    logic [XLEN-1:0] ext_imm_c;
    logic            ext_err_c;
    logic            in_xfer_c;
    logic            out_xfer_c;

    // Format the incoming immediate according to the mode code.
    always_comb begin
        sext_c    = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
        ext_imm_c = '0;
        ext_err_c = 1'b0;
        case (in_mode)
            3'd0:    ext_imm_c = sext_c;
            3'd1:    ext_imm_c = {{EXT_W{1'b0}}, in_imm};
            3'd2:    ext_imm_c = {in_imm, {EXT_W{1'b0}}};
            3'd3:    ext_imm_c = sext_c << BR_SHIFT;
            3'd4:    ext_imm_c = '0;
            default: ext_err_c = 1'b1;
        endcase
    end

    // Occupancy next-state and buffer data movement.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_err_d = main_err_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        in_xfer_c  = in_valid && in_ready_q;
        out_xfer_c = out_valid_q && out_ready;

        case (state_q)
            OCC_EMPTY: begin
                if (in_xfer_c) begin
                    main_imm_d = ext_imm_c;
                    main_err_d = ext_err_c;
                    state_d    = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    // Main drains and refills on the same edge.
                    main_imm_d = ext_imm_c;
                    main_err_d = ext_err_c;
                end else if (in_xfer_c) begin
                    // Main is stalled; park the new result in the skid entry.
                    skid_imm_d = ext_imm_c;
                    skid_err_d = ext_err_c;
                    state_d    = OCC_TWO;
                end else if (out_xfer_c) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (out_xfer_c) begin
                    main_imm_d = skid_imm_q;
                    main_err_d = skid_err_q;
                    state_d    = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase

        in_ready_d  = (state_d != OCC_TWO);
        out_valid_d = (state_d != OCC_EMPTY);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= OCC_EMPTY;
            main_imm_q  <= '0;
            main_err_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_imm_q  <= main_imm_d;
            main_err_q  <= main_err_d;
            skid_imm_q  <= skid_imm_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = main_imm_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed cases plus a randomized stream
// checked through an in-order scoreboard.
module tb_imm_extend_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 16;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] in_imm;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    logic mon_en = 1'b0;
    logic rnd_done;

    imm_extend_pipe #(.XLEN(XLEN), .IMM_W(IMM_W), .BR_SHIFT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference immediate formatter.
    function automatic exp_t model(input logic [IMM_W-1:0] imm, input logic [2:0] mode);
        exp_t r;
        logic signed [XLEN-1:0] s;
        s     = XLEN'($signed(imm));
        r.imm = '0;
        r.err = 1'b0;
        case (mode)
            3'd0: r.imm = s;
            3'd1: r.imm = XLEN'(imm);
            3'd2: r.imm = {imm, 16'h0000};
            3'd3: r.imm = s * 4;
            3'd4: r.imm = '0;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Output monitor: every output transfer must match the queue head.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_output", 64'(out_imm), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_imm", 64'(out_imm), 64'(e.imm));
                check_val("sb_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    // Present one item (called just after a posedge) and push its expectation once accepted.
    task automatic send(input logic [IMM_W-1:0] imm, input logic [2:0] mode, input exp_t e);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb_q.push_back(e);
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_val("send_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_imm   = $urandom();
        in_mode  = 3'($urandom());
    endtask

    // Wait for the scoreboard to empty, bounded.
    task automatic drain();
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(posedge clk);
        check_val("drain_left", 64'(sb_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;

        // Reset held for two edges.
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_imm",   64'(out_imm),   64'(0));
        check_val("rst_out_err",   64'(out_err),   64'(0));
        check_val("rst_in_ready",  64'(in_ready),  64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rel_in_ready",  64'(in_ready),  64'(1));
        check_val("rel_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Fixed format cases with literal expectations.
        e = '{imm: 32'hFFFF8004, err: 1'b0}; send(16'h8004, 3'd0, e);
        e = '{imm: 32'h00008004, err: 1'b0}; send(16'h8004, 3'd1, e);
        e = '{imm: 32'h12340000, err: 1'b0}; send(16'h1234, 3'd2, e);
        e = '{imm: 32'hFFFFFFFC, err: 1'b0}; send(16'hFFFF, 3'd3, e);
        e = '{imm: 32'h00000000, err: 1'b0}; send(16'hABCD, 3'd4, e);
        e = '{imm: 32'h00000000, err: 1'b1}; send(16'h00FF, 3'd5, e);
        e = '{imm: 32'h00000005, err: 1'b0}; send(16'h0005, 3'd0, e);
        e = '{imm: 32'h00000000, err: 1'b1}; send(16'h7FFF, 3'd7, e);
        e = '{imm: 32'h0001FFFC, err: 1'b0}; send(16'h7FFF, 3'd3, e);
        drain();

        // Backpressure: two items fill main and skid.
        out_ready = 1'b0;
        e = '{imm: 32'h00000001, err: 1'b0}; send(16'h0001, 3'd0, e);
        e = '{imm: 32'h00000002, err: 1'b0}; send(16'h0002, 3'd0, e);
        @(negedge clk);
        check_val("bp_in_ready",  64'(in_ready),  64'(0));
        check_val("bp_out_valid", 64'(out_valid), 64'(1));
        check_val("bp_hold_imm",  64'(out_imm),   64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_hold_imm2", 64'(out_imm),   64'(1));
        check_val("bp_in_ready2", 64'(in_ready),  64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_first",     64'(out_imm),   64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_second",    64'(out_imm),   64'(2));
        check_val("bp_out_valid2",64'(out_valid), 64'(1));
        check_val("bp_in_ready3", 64'(in_ready),  64'(1));
        drain();

        // Random stream with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [IMM_W-1:0] r_imm;
                    logic [2:0]       r_mode;
                    r_imm  = IMM_W'($urandom());
                    r_mode = 3'($urandom_range(0, 7));
                    send(r_imm, r_mode, model(r_imm, r_mode));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset while two entries are held: results must vanish.
        out_ready = 1'b0;
        e = '{imm: 32'h00000011, err: 1'b0}; send(16'h0011, 3'd0, e);
        e = '{imm: 32'h00000022, err: 1'b0}; send(16'h0022, 3'd0, e);
        @(negedge clk);
        check_val("pre_rst_full", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check_val("mid_rst_out_imm",   64'(out_imm),   64'(0));
        check_val("mid_rst_in_ready",  64'(in_ready),  64'(0));
        sb_q.delete();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("post_rst_idle", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        e = '{imm: 32'h00340000, err: 1'b0}; send(16'h0034, 3'd2, e);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
